// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: merges stage stall requests, tracks multi-cycle EX ops,
// and issues flush/redirect on MEM exceptions.
module pipe_ctrl #(
    parameter int CNT_W = 6,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_mem,
    input  logic             ex_mc_start,
    input  logic [CNT_W-1:0] ex_mc_cycles,
    input  logic             ex_mc_cancel,
    input  logic             excp_req,
    input  logic [PC_W-1:0]  excp_pc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [PC_W-1:0]  new_pc,
    output logic             ex_mc_busy,
    output logic             ex_mc_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [5:0] STALL_IF  = 6'b000011;
    localparam logic [5:0] STALL_ID  = 6'b000111;
    localparam logic [5:0] STALL_EX  = 6'b001111;
    localparam logic [5:0] STALL_MEM = 6'b011111;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] start_cnt;
    logic             ex_req;

    // Zero-length ops are resolved to one cycle, so the counter starts at len-1.
    assign start_cnt = (ex_mc_cycles == '0) ? '0 : ex_mc_cycles - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            pc_q  <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            pc_q  <= pc_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        pc_d    = pc_q;
        unique case (state)
            IDLE: begin
                if (excp_req) begin
                    state_d = FLUSH;
                    pc_d    = excp_pc;
                end else if (ex_mc_start) begin
                    cnt_d   = start_cnt;
                    state_d = (start_cnt == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt - 1'b1;
                if (excp_req) begin
                    state_d = FLUSH;
                    pc_d    = excp_pc;
                    cnt_d   = '0;
                end else if (ex_mc_cancel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (excp_req) begin
                    state_d = FLUSH;
                    pc_d    = excp_pc;
                end else if (!stallreq_mem) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (excp_req) begin
                    pc_d = excp_pc;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ex_req = ((state == IDLE) && ex_mc_start && !excp_req) || (state == BUSY);

    always_comb begin
        stall = '0;
        if (stallreq_if)  stall = stall | STALL_IF;
        if (stallreq_id)  stall = stall | STALL_ID;
        if (ex_req)       stall = stall | STALL_EX;
        if (stallreq_mem) stall = stall | STALL_MEM;
        if (rst || excp_req || (state == FLUSH)) stall = '0;
    end

    // Outputs are forced low during reset, before the first reset edge has settled state.
    assign flush      = !rst && (state == FLUSH);
    assign new_pc     = rst ? '0 : pc_q;
    assign ex_mc_busy = !rst && (state == BUSY);
    assign ex_mc_done = !rst && (state == DONE);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with hand-computed expectations.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_mem;
    logic        ex_mc_start;
    logic [5:0]  ex_mc_cycles;
    logic        ex_mc_cancel;
    logic        excp_req;
    logic [31:0] excp_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        ex_mc_busy, ex_mc_done;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    pipe_ctrl #(.CNT_W(6), .PC_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_mem (stallreq_mem),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_cycles (ex_mc_cycles),
        .ex_mc_cancel (ex_mc_cancel),
        .excp_req     (excp_req),
        .excp_pc      (excp_pc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .ex_mc_busy   (ex_mc_busy),
        .ex_mc_done   (ex_mc_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; inputs are then set and outputs sampled mid-cycle.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        stallreq_if  = 1'b0;
        stallreq_id  = 1'b0;
        stallreq_mem = 1'b0;
        ex_mc_start  = 1'b0;
        ex_mc_cycles = '0;
        ex_mc_cancel = 1'b0;
        excp_req     = 1'b0;
        excp_pc      = '0;
    endtask

    task automatic chk_all(input string tag, input logic [5:0] e_stall, input logic e_flush,
                           input logic e_busy, input logic e_done);
        chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
        chk({tag, ".flush"}, 32'(flush), 32'(e_flush));
        chk({tag, ".busy"},  32'(ex_mc_busy), 32'(e_busy));
        chk({tag, ".done"},  32'(ex_mc_done), 32'(e_done));
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;

        // Reset with competing requests
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            stallreq_mem = 1'b1; excp_req = 1'b1; excp_pc = 32'hDEAD_BEEF;
            #1;
            chk_all("rst", 6'b000000, 1'b0, 1'b0, 1'b0);
            chk("rst.new_pc", new_pc, 32'h0);
        end
        next_cycle(); rst = 1'b0; clear_inputs(); #1;
        chk_all("post_rst", 6'b000000, 1'b0, 1'b0, 1'b0);
        chk("post_rst.new_pc", new_pc, 32'h0);

        // Stall merge
        next_cycle(); stallreq_if = 1'b1; #1;
        chk("merge_if", 32'(stall), 32'h03);
        next_cycle(); stallreq_if = 1'b0; stallreq_id = 1'b1; #1;
        chk("merge_id", 32'(stall), 32'h07);
        next_cycle(); stallreq_mem = 1'b1; #1;
        chk("merge_id_mem", 32'(stall), 32'h1F);
        next_cycle(); clear_inputs(); #1;
        chk("merge_clear", 32'(stall), 32'h00);

        // Multi-cycle length 4
        next_cycle(); ex_mc_start = 1'b1; ex_mc_cycles = 6'd4; #1;
        chk_all("mc4.start", 6'b001111, 1'b0, 1'b0, 1'b0);
        next_cycle(); clear_inputs(); #1;
        chk_all("mc4.b1", 6'b001111, 1'b0, 1'b1, 1'b0);
        next_cycle(); #1;
        chk_all("mc4.b2", 6'b001111, 1'b0, 1'b1, 1'b0);
        next_cycle(); #1;
        chk_all("mc4.b3", 6'b001111, 1'b0, 1'b1, 1'b0);
        next_cycle(); #1;
        chk_all("mc4.done", 6'b000000, 1'b0, 1'b0, 1'b1);
        next_cycle(); #1;
        chk_all("mc4.idle", 6'b000000, 1'b0, 1'b0, 1'b0);

        // Zero length resolves to one cycle; start in DONE is ignored
        next_cycle(); ex_mc_start = 1'b1; ex_mc_cycles = 6'd0; #1;
        chk_all("mc0.start", 6'b001111, 1'b0, 1'b0, 1'b0);
        next_cycle(); ex_mc_cycles = 6'd5; #1;
        chk_all("mc0.done", 6'b000000, 1'b0, 1'b0, 1'b1);
        next_cycle(); clear_inputs(); #1;
        chk_all("mc0.idle", 6'b000000, 1'b0, 1'b0, 1'b0);

        // Done held by MEM stall
        next_cycle(); ex_mc_start = 1'b1; ex_mc_cycles = 6'd3; #1;
        chk_all("hold.start", 6'b001111, 1'b0, 1'b0, 1'b0);
        next_cycle(); clear_inputs(); #1;
        chk_all("hold.b1", 6'b001111, 1'b0, 1'b1, 1'b0);
        next_cycle(); #1;
        chk_all("hold.b2", 6'b001111, 1'b0, 1'b1, 1'b0);
        next_cycle(); stallreq_mem = 1'b1; #1;
        chk_all("hold.d1", 6'b011111, 1'b0, 1'b0, 1'b1);
        next_cycle(); #1;
        chk_all("hold.d2", 6'b011111, 1'b0, 1'b0, 1'b1);
        next_cycle(); stallreq_mem = 1'b0; #1;
        chk_all("hold.d3", 6'b000000, 1'b0, 1'b0, 1'b1);
        next_cycle(); #1;
        chk_all("hold.idle", 6'b000000, 1'b0, 1'b0, 1'b0);

        // Exception mid-op, then back-to-back exception in FLUSH
        next_cycle(); ex_mc_start = 1'b1; ex_mc_cycles = 6'd5; #1;
        chk_all("excp.start", 6'b001111, 1'b0, 1'b0, 1'b0);
        next_cycle(); clear_inputs(); #1;
        chk_all("excp.b1", 6'b001111, 1'b0, 1'b1, 1'b0);
        next_cycle(); excp_req = 1'b1; excp_pc = 32'h0000_0180; #1;
        chk_all("excp.b2", 6'b000000, 1'b0, 1'b1, 1'b0);
        next_cycle(); excp_pc = 32'h0000_0200; stallreq_if = 1'b1; #1;
        chk_all("excp.fl1", 6'b000000, 1'b1, 1'b0, 1'b0);
        chk("excp.fl1.new_pc", new_pc, 32'h0000_0180);
        next_cycle(); clear_inputs(); #1;
        chk_all("excp.fl2", 6'b000000, 1'b1, 1'b0, 1'b0);
        chk("excp.fl2.new_pc", new_pc, 32'h0000_0200);
        next_cycle(); #1;
        chk_all("excp.idle", 6'b000000, 1'b0, 1'b0, 1'b0);
        next_cycle(); #1;
        chk_all("excp.idle2", 6'b000000, 1'b0, 1'b0, 1'b0);

        // Cancel in BUSY
        next_cycle(); ex_mc_start = 1'b1; ex_mc_cycles = 6'd6; #1;
        chk_all("cancel.start", 6'b001111, 1'b0, 1'b0, 1'b0);
        next_cycle(); clear_inputs(); #1;
        chk_all("cancel.b1", 6'b001111, 1'b0, 1'b1, 1'b0);
        next_cycle(); ex_mc_cancel = 1'b1; #1;
        chk_all("cancel.b2", 6'b001111, 1'b0, 1'b1, 1'b0);
        next_cycle(); clear_inputs(); #1;
        chk_all("cancel.idle", 6'b000000, 1'b0, 1'b0, 1'b0);
        next_cycle(); #1;
        chk_all("cancel.idle2", 6'b000000, 1'b0, 1'b0, 1'b0);

        // Start together with exception in IDLE
        next_cycle(); ex_mc_start = 1'b1; ex_mc_cycles = 6'd4;
        excp_req = 1'b1; excp_pc = 32'h0000_0300; #1;
        chk_all("simul.req", 6'b000000, 1'b0, 1'b0, 1'b0);
        next_cycle(); clear_inputs(); #1;
        chk_all("simul.flush", 6'b000000, 1'b1, 1'b0, 1'b0);
        chk("simul.new_pc", new_pc, 32'h0000_0300);
        next_cycle(); #1;
        chk_all("simul.idle", 6'b000000, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Merges stall requests from the IF, ID and MEM stages with its own multi-cycle EX tracking into one stall vector that gates the PC and the pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Sequences multi-cycle EX operations (madd/msub/div) with a cycle counter and FSM.
- Generates the pipeline flush and redirect PC when MEM reports an exception.

Parameters:
- CNT_W, 6, width of multi-cycle length input and internal down-counter
- PC_W, 32, width of exception/redirect PC

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-high
- stallreq_if  in  1  IF stage stall request
- stallreq_id  in  1  ID stage stall request (load-use etc.)
- stallreq_mem  in  1  MEM stage stall request
- ex_mc_start  in  1  EX begins a multi-cycle op this cycle
- ex_mc_cycles  in  CNT_W  total EX cycles for the op; 0 treated as 1
- ex_mc_cancel  in  1  abort in-flight multi-cycle op
- excp_req  in  1  MEM stage exception taken
- excp_pc  in  PC_W  handler address for excp_req
- stall  out  6  [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] reserved (always 0)
- flush  out  1  clear all pipeline registers
- new_pc  out  PC_W  redirect PC, valid while flush=1
- ex_mc_busy  out  1  multi-cycle op in progress
- ex_mc_done  out  1  multi-cycle result may be captured by EX/MEM

Behaviour:
- Clock and reset:
  - Single clock; rst sampled on posedge clk, active-high.
  - rst=1 forces state IDLE, cnt=0, new_pc=0.
  - While rst=1, all outputs are 0, including the combinational stall.
- States: IDLE, BUSY, DONE, FLUSH. Registers are state, cnt and new_pc.
- Stall encodings:
  - IF request = 6'b000011
  - ID request = 6'b000111
  - EX-internal request = 6'b001111
  - MEM request = 6'b011111
- Stall combination:
  - stall is combinational: the bitwise OR of all active encodings.
  - The EX-internal request is active when (state==IDLE & ex_mc_start & !excp_req) or state==BUSY.
  - stall=0 whenever excp_req=1 or state==FLUSH.
- IDLE:
  - excp_req → FLUSH; new_pc<=excp_pc.
  - Else if ex_mc_start: cnt<=max(ex_mc_cycles,1)-1. If that value is 0, next state is DONE; otherwise BUSY.
- BUSY:
  - ex_mc_busy=1; cnt decrements every cycle, regardless of stallreq_mem.
  - excp_req → FLUSH (op dropped, new_pc latched).
  - Else if ex_mc_cancel → IDLE, no done.
  - Else if cnt==1 → DONE.
  - Total stall cycles from start to DONE equal the resolved length N = max(ex_mc_cycles,1). Example: 4 cycles for ex_mc_cycles=4, counting the start cycle.
- DONE:
  - ex_mc_done=1; EX-internal request is inactive.
  - Stays in DONE while stallreq_mem=1, with done held high.
  - → IDLE when stallreq_mem=0.
  - excp_req → FLUSH.
  - ex_mc_start is ignored in DONE.
- FLUSH:
  - flush=1, new_pc stable, stall=0; lasts exactly one cycle.
  - A new excp_req in FLUSH re-latches new_pc and stays in FLUSH one more cycle; otherwise → IDLE.
  - All other requests in FLUSH are ignored.
- Latency and priority:
  - flush rises the cycle after excp_req.
  - Priority: rst > excp_req > ex_mc_cancel > counting/start.
- ex_mc_busy and ex_mc_done are decoded from the registered state and are glitch-free.

Test Plan:
- Reset: hold rst=1 two cycles with stallreq_mem=1 and excp_req=1 → stall=0, flush=0, new_pc=0, busy=0; after release, state IDLE.
- Stall merge: stallreq_if=1, then stallreq_id=1, then stallreq_id and stallreq_mem both 1 → stall=6'b000011, 6'b000111, 6'b011111, each in the same cycle as its request.
- Multi-cycle, ex_mc_cycles=4: stall=6'b001111 for 4 cycles (start plus 3 BUSY) → ex_mc_done=1 with stall=0 for one cycle → IDLE. Also ex_mc_cycles=0 → one stall cycle, then done.
- Done held: ex_mc_cycles=3 with stallreq_mem=1 from the done cycle for 2 cycles → done stays high 3 cycles, stall=6'b011111 while held, then IDLE.
- Exception mid-op: excp_req=1 with excp_pc=32'h0000_0180 in the 2nd BUSY cycle → stall=0 that cycle; next cycle flush=1 and new_pc=32'h180; no ex_mc_done ever; back-to-back excp_req in FLUSH re-latches the new PC.
- Cancel and simultaneity: ex_mc_cancel in BUSY → IDLE next cycle, no done. ex_mc_start together with excp_req in IDLE → FLUSH taken, no BUSY.
